// File: rtl/ex_stage_pkg.sv
// Shared decode/execute definitions: operation encodings and write-enable constants.
package ex_stage_pkg;

   typedef enum logic [7:0] {
      ALU_NOP  = 8'b00000000,
      ALU_AND  = 8'b00100100,
      ALU_OR   = 8'b00100101,
      ALU_XOR  = 8'b00100110,
      ALU_NOR  = 8'b00100111,
      ALU_LUI  = 8'b01011100,
      ALU_SLL  = 8'b01111100,
      ALU_SRL  = 8'b00000010,
      ALU_SRA  = 8'b00000011,
      ALU_MOVZ = 8'b00001010,
      ALU_MOVN = 8'b00001011,
      ALU_MFHI = 8'b00010000,
      ALU_MTHI = 8'b00010001,
      ALU_MFLO = 8'b00010010,
      ALU_MTLO = 8'b00010011
   } aluop_e;

   typedef enum logic [2:0] {
      SEL_NOP   = 3'b000,
      SEL_LOGIC = 3'b001,
      SEL_SHIFT = 3'b010,
      SEL_MOVE  = 3'b011
   } alusel_e;

   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;

endpackage

// File: rtl/ex_stage_hilo_reg.sv
// HI/LO special register pair with independent write enables and synchronous reset.
module hilo_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_weHi,
   input  logic              i_weLo,
   input  logic [DATA_W-1:0] i_hi,
   input  logic [DATA_W-1:0] i_lo,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (i_weHi) r_hi <= i_hi;
         if (i_weLo) r_lo <= i_lo;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: logic/shift/move results, HI/LO ownership, forwarding bus and EX/MEM register.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic [7:0]        aluop_i,
   input  logic [2:0]        alusel_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [REG_AW-1:0] wd_i,
   input  logic              wreg_i,
   output logic              ex_wreg_o,
   output logic [REG_AW-1:0] ex_wd_o,
   output logic [DATA_W-1:0] ex_wdata_o,
   output logic              mem_wreg_o,
   output logic [REG_AW-1:0] mem_wd_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   aluop_e            w_op;
   alusel_e           w_sel;
   logic [4:0]        w_sa;
   logic [DATA_W-1:0] w_logicRes;
   logic [DATA_W-1:0] w_shiftRes;
   logic [DATA_W-1:0] w_moveRes;
   logic [DATA_W-1:0] w_result;
   logic              w_wreg;
   logic              w_weHi;
   logic              w_weLo;
   logic              w_reg2Zero;

   logic              r_memWreg;
   logic [REG_AW-1:0] r_memWd;
   logic [DATA_W-1:0] r_memWdata;

   assign w_op       = aluop_e'(aluop_i);
   assign w_sel      = alusel_e'(alusel_i);
   assign w_sa       = reg1_i[4:0];
   assign w_reg2Zero = (reg2_i == '0);

   always_comb begin
      w_logicRes = '0;
      case (w_op)
         ALU_AND:         w_logicRes = reg1_i & reg2_i;
         ALU_OR, ALU_LUI: w_logicRes = reg1_i | reg2_i;
         ALU_XOR:         w_logicRes = reg1_i ^ reg2_i;
         ALU_NOR:         w_logicRes = ~(reg1_i | reg2_i);
         default:         w_logicRes = '0;
      endcase
   end

   always_comb begin
      w_shiftRes = '0;
      case (w_op)
         ALU_SLL: w_shiftRes = reg2_i << w_sa;
         ALU_SRL: w_shiftRes = reg2_i >> w_sa;
         ALU_SRA: w_shiftRes = DATA_W'($signed(reg2_i) >>> w_sa);
         default: w_shiftRes = '0;
      endcase
   end

   always_comb begin
      w_moveRes = '0;
      case (w_op)
         ALU_MFHI:           w_moveRes = hi_o;
         ALU_MFLO:           w_moveRes = lo_o;
         ALU_MOVZ, ALU_MOVN: w_moveRes = reg1_i;
         default:            w_moveRes = '0;
      endcase
   end

   // Conditional moves are re-gated here from reg2 rather than trusting decode's wreg.
   always_comb begin
      w_result = '0;
      w_wreg   = wreg_i;
      w_weHi   = WriteDisable;
      w_weLo   = WriteDisable;
      case (w_sel)
         SEL_LOGIC: w_result = w_logicRes;
         SEL_SHIFT: w_result = w_shiftRes;
         SEL_MOVE:  w_result = w_moveRes;
         default:   w_result = '0;
      endcase
      case (w_op)
         ALU_MOVZ: w_wreg = wreg_i & w_reg2Zero;
         ALU_MOVN: w_wreg = wreg_i & ~w_reg2Zero;
         ALU_MTHI: begin
            w_wreg = WriteDisable;
            w_weHi = WriteEnable;
         end
         ALU_MTLO: begin
            w_wreg = WriteDisable;
            w_weLo = WriteEnable;
         end
         default: ;
      endcase
   end

   assign ex_wreg_o  = rst ? 1'b0 : w_wreg;
   assign ex_wd_o    = rst ? '0 : wd_i;
   assign ex_wdata_o = rst ? '0 : w_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_memWreg  <= 1'b0;
         r_memWd    <= '0;
         r_memWdata <= '0;
      end else if (!stall_i) begin
         r_memWreg  <= ex_wreg_o;
         r_memWd    <= ex_wd_o;
         r_memWdata <= ex_wdata_o;
      end
   end

   assign mem_wreg_o  = r_memWreg;
   assign mem_wd_o    = r_memWd;
   assign mem_wdata_o = r_memWdata;

   hilo_reg #(
      .DATA_W (DATA_W)
   ) uHiloReg (
      .clk    (clk),
      .rst    (rst),
      .i_weHi (w_weHi & ~stall_i),
      .i_weLo (w_weLo & ~stall_i),
      .i_hi   (reg1_i),
      .i_lo   (reg1_i),
      .o_hi   (hi_o),
      .o_lo   (lo_o)
   );

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

   localparam logic [7:0] OP_NOP  = 8'b00000000;
   localparam logic [7:0] OP_AND  = 8'b00100100;
   localparam logic [7:0] OP_OR   = 8'b00100101;
   localparam logic [7:0] OP_XOR  = 8'b00100110;
   localparam logic [7:0] OP_NOR  = 8'b00100111;
   localparam logic [7:0] OP_LUI  = 8'b01011100;
   localparam logic [7:0] OP_SLL  = 8'b01111100;
   localparam logic [7:0] OP_SRL  = 8'b00000010;
   localparam logic [7:0] OP_SRA  = 8'b00000011;
   localparam logic [7:0] OP_MOVZ = 8'b00001010;
   localparam logic [7:0] OP_MOVN = 8'b00001011;
   localparam logic [7:0] OP_MFHI = 8'b00010000;
   localparam logic [7:0] OP_MTHI = 8'b00010001;
   localparam logic [7:0] OP_MFLO = 8'b00010010;
   localparam logic [7:0] OP_MTLO = 8'b00010011;

   localparam logic [2:0] S_NOP   = 3'b000;
   localparam logic [2:0] S_LOGIC = 3'b001;
   localparam logic [2:0] S_SHIFT = 3'b010;
   localparam logic [2:0] S_MOVE  = 3'b011;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic        ex_wreg_o;
   logic [4:0]  ex_wd_o;
   logic [31:0] ex_wdata_o;
   logic        mem_wreg_o;
   logic [4:0]  mem_wd_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checkCount;
   int errorCount;

   ex_stage #(
      .DATA_W (32),
      .REG_AW (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .aluop_i     (aluop_i),
      .alusel_i    (alusel_i),
      .reg1_i      (reg1_i),
      .reg2_i      (reg2_i),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .ex_wreg_o   (ex_wreg_o),
      .ex_wd_o     (ex_wd_o),
      .ex_wdata_o  (ex_wdata_o),
      .mem_wreg_o  (mem_wreg_o),
      .mem_wd_o    (mem_wd_o),
      .mem_wdata_o (mem_wdata_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Inputs change mid-cycle; the #1 lets the combinational forwarding path settle.
   task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] wd, input logic wreg);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = r1;
      reg2_i   = r2;
      wd_i     = wd;
      wreg_i   = wreg;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      stall_i    = 1'b0;
      applyStimulus(OP_OR, S_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
      checkOutput("ex_wdata_in_reset", ex_wdata_o, 32'h0);
      checkOutput("ex_wreg_in_reset", {31'b0, ex_wreg_o}, 32'h0);
      step();
      checkOutput("reset_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
      checkOutput("reset_mem_wdata", mem_wdata_o, 32'h0);
      checkOutput("reset_hi", hi_o, 32'h0);
      checkOutput("reset_lo", lo_o, 32'h0);
      rst = 1'b0;

      applyStimulus(OP_OR, S_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
      checkOutput("or_ex_wdata", ex_wdata_o, 32'h0000_FFFF);
      checkOutput("or_ex_wreg", {31'b0, ex_wreg_o}, 32'h1);
      checkOutput("or_ex_wd", {27'b0, ex_wd_o}, 32'd5);
      step();
      checkOutput("or_mem_wdata", mem_wdata_o, 32'h0000_FFFF);
      checkOutput("or_mem_wd", {27'b0, mem_wd_o}, 32'd5);
      checkOutput("or_mem_wreg", {31'b0, mem_wreg_o}, 32'h1);

      applyStimulus(OP_AND, S_LOGIC, 32'h0000_F0F0, 32'h0000_0FFF, 5'd1, 1'b1);
      checkOutput("and", ex_wdata_o, 32'h0000_00F0);
      applyStimulus(OP_XOR, S_LOGIC, 32'h0000_FF00, 32'h0000_0FF0, 5'd1, 1'b1);
      checkOutput("xor", ex_wdata_o, 32'h0000_F0F0);
      applyStimulus(OP_NOR, S_LOGIC, 32'h0, 32'h0, 5'd1, 1'b1);
      checkOutput("nor", ex_wdata_o, 32'hFFFF_FFFF);
      applyStimulus(OP_LUI, S_LOGIC, 32'h0, 32'h1234_0000, 5'd1, 1'b1);
      checkOutput("lui", ex_wdata_o, 32'h1234_0000);
      applyStimulus(OP_SRA, S_SHIFT, 32'd4, 32'h8000_0000, 5'd2, 1'b1);
      checkOutput("sra", ex_wdata_o, 32'hF800_0000);
      applyStimulus(OP_SRL, S_SHIFT, 32'd4, 32'h8000_0000, 5'd2, 1'b1);
      checkOutput("srl", ex_wdata_o, 32'h0800_0000);
      applyStimulus(OP_SLL, S_SHIFT, 32'h21, 32'h1, 5'd2, 1'b1);
      checkOutput("sll_sa_upper_ignored", ex_wdata_o, 32'h2);
      applyStimulus(OP_OR, 3'b111, 32'h1, 32'h2, 5'd2, 1'b1);
      checkOutput("unknown_alusel", ex_wdata_o, 32'h0);
      applyStimulus(OP_NOP, S_NOP, 32'h5, 32'h6, 5'd0, 1'b0);
      checkOutput("nop", ex_wdata_o, 32'h0);

      applyStimulus(OP_MOVZ, S_MOVE, 32'h1234, 32'h0, 5'd3, 1'b1);
      checkOutput("movz_taken_wreg", {31'b0, ex_wreg_o}, 32'h1);
      checkOutput("movz_taken_data", ex_wdata_o, 32'h1234);
      applyStimulus(OP_MOVZ, S_MOVE, 32'h1234, 32'h1, 5'd3, 1'b1);
      checkOutput("movz_not_taken_wreg", {31'b0, ex_wreg_o}, 32'h0);
      applyStimulus(OP_MOVN, S_MOVE, 32'h77, 32'h0, 5'd3, 1'b1);
      checkOutput("movn_not_taken_wreg", {31'b0, ex_wreg_o}, 32'h0);
      applyStimulus(OP_MOVN, S_MOVE, 32'h77, 32'h5, 5'd3, 1'b1);
      checkOutput("movn_taken_wreg", {31'b0, ex_wreg_o}, 32'h1);
      checkOutput("movn_taken_data", ex_wdata_o, 32'h77);

      applyStimulus(OP_MTHI, S_NOP, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1);
      checkOutput("mthi_ex_wreg", {31'b0, ex_wreg_o}, 32'h0);
      step();
      checkOutput("mthi_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
      applyStimulus(OP_MFHI, S_MOVE, 32'h0, 32'h0, 5'd8, 1'b1);
      checkOutput("mfhi_ex_wdata", ex_wdata_o, 32'hDEAD_BEEF);
      checkOutput("mfhi_hi", hi_o, 32'hDEAD_BEEF);
      checkOutput("mfhi_lo_untouched", lo_o, 32'h0);

      applyStimulus(OP_MTLO, S_NOP, 32'hAA, 32'h0, 5'd0, 1'b0);
      step();
      applyStimulus(OP_MFLO, S_MOVE, 32'h0, 32'h0, 5'd9, 1'b1);
      checkOutput("mflo_ex_wdata", ex_wdata_o, 32'hAA);
      applyStimulus(OP_OR, S_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
      step();
      stall_i = 1'b1;
      applyStimulus(OP_MTLO, S_NOP, 32'h55, 32'h0, 5'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         checkOutput("stall_lo_hold", lo_o, 32'hAA);
         checkOutput("stall_mem_wdata_hold", mem_wdata_o, 32'h0000_FFFF);
         checkOutput("stall_mem_wreg_hold", {31'b0, mem_wreg_o}, 32'h1);
         checkOutput("stall_mem_wd_hold", {27'b0, mem_wd_o}, 32'd5);
      end
      stall_i = 1'b0;
      #1;
      step();
      checkOutput("release_lo", lo_o, 32'h55);
      checkOutput("release_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
      checkOutput("release_mem_wdata", mem_wdata_o, 32'h0);

      applyStimulus(OP_MTHI, S_NOP, 32'h1, 32'h0, 5'd0, 1'b0);
      step();
      checkOutput("mthi_one", hi_o, 32'h1);
      applyStimulus(OP_OR, S_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
      step();
      rst     = 1'b1;
      stall_i = 1'b1;
      applyStimulus(OP_MTHI, S_NOP, 32'h2, 32'h0, 5'd0, 1'b0);
      step();
      checkOutput("rst_stall_hi", hi_o, 32'h0);
      checkOutput("rst_stall_lo", lo_o, 32'h0);
      checkOutput("rst_stall_mem_wreg", {31'b0, mem_wreg_o}, 32'h0);
      checkOutput("rst_stall_mem_wdata", mem_wdata_o, 32'h0);
      checkOutput("rst_stall_mem_wd", {27'b0, mem_wd_o}, 32'h0);
      rst     = 1'b0;
      stall_i = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS32 pipeline. Consumes the decoded operation and operands from the decode stage and computes logic, shift and move results. Owns the HI/LO special registers. Drives the combinational forwarding bus back to decode and the registered EX/MEM pipeline outputs toward the memory stage.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register address width

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge
- `rst`  in  1  — reset: synchronous, active-high
- `stall_i`  in  1  — downstream stall; freezes all state
- `aluop_i`  in  8  — operation subtype from decode
- `alusel_i`  in  3  — result class from decode
- `reg1_i`, `reg2_i`  in  DATA_W  — source operands, already forwarded or replaced by the immediate
- `wd_i`  in  REG_AW  — destination register
- `wreg_i`  in  1  — destination write enable from decode
- `ex_wreg_o`, `ex_wd_o`, `ex_wdata_o`  out  1/REG_AW/DATA_W  — combinational result, forwarded to decode in the same cycle
- `mem_wreg_o`, `mem_wd_o`, `mem_wdata_o`  out  1/REG_AW/DATA_W  — registered EX/MEM outputs
- `hi_o`, `lo_o`  out  DATA_W  — current HI and LO register contents

## Operation
- Encodings (aluop): NOP 00000000, AND 00100100, OR 00100101, XOR 00100110, NOR 00100111, LUI 01011100, SLL 01111100, SRL 00000010, SRA 00000011, MOVZ 00001010, MOVN 00001011, MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011.
- Encodings (alusel): NOP 000, LOGIC 001, SHIFT 010, MOVE 011.
- Logic results:
  - AND: reg1&reg2; OR and LUI: reg1|reg2; XOR: reg1^reg2; NOR: ~(reg1|reg2).
  - Decode supplies the LUI immediate pre-shifted in reg2 and rs (=0) in reg1.
- Shift results (shift amount = reg1_i[4:0]; upper bits ignored):
  - SLL: reg2<<sa; SRL: logical right; SRA: arithmetic right, sign-filled from reg2[31].
- Move results:
  - MFHI → HI; MFLO → LO; MOVZ and MOVN → reg1.
- Result mux selects on `alusel_i`; NOP or an unknown alusel gives result 0.
- Write-enable gating:
  - `ex_wreg_o` = `wreg_i`, except MOVZ writes only if reg2==0 and MOVN only if reg2!=0.
  - The stage re-evaluates the MOVZ/MOVN condition itself and does not trust decode's gating.
- HI/LO updates:
  - MTHI: HI←reg1 at the clock edge; MTLO: LO←reg1 at the clock edge.
  - Neither writes the GPR file (`ex_wreg_o`=0 regardless of `wreg_i`).
- `ex_wd_o` = `wd_i`.

## Timing
- Forwarding outputs `ex_*` are purely combinational, with zero latency from the inputs.
- EX/MEM path: `mem_*` ← `ex_*` on each rising edge when `stall_i`=0, giving 1-cycle latency. When `stall_i`=1, `mem_*` hold.
- HI/LO write on the rising edge when `stall_i`=0; a stall suppresses the write.
- An MFHI issued in the cycle right after an MTHI reads the new HI value; no HI/LO forwarding path is needed.
- `rst`=1 at an edge sets `mem_wreg_o`=0, `mem_wd_o`=0, `mem_wdata_o`=0, HI=0 and LO=0.
  - Reset overrides `stall_i`.
  - Reset also aborts any MTHI/MTLO in flight.
- While `rst` is high, the `ex_*` outputs are forced to 0.
- Simultaneous stall and MTHI: no write happens. The same instruction is presented again and writes once the stall releases.

## Structure
- A shared definitions package holds the aluop and alusel encodings, ZeroWord, and WriteEnable/WriteDisable. Decode uses the same package.
- Sub-module `hilo_reg` holds the HI/LO pair with we_hi, we_lo and synchronous reset. The rest of the block is inline (result mux plus the EX/MEM register).

## Test plan
1. OR with reg1=0x0000F0F0, reg2=0x00000F0F, wd=5, wreg=1 → ex_wdata=0x0000FFFF combinationally; one cycle later mem_wdata=0x0000FFFF, mem_wd=5, mem_wreg=1.
2. SRA with reg1=4, reg2=0x80000000 → 0xF8000000. SRL with the same operands → 0x08000000. SLL with reg1=0x21 (sa=1), reg2=1 → 2.
3. MOVZ with reg2=0, reg1=0x1234 → wreg=1, data=0x1234. MOVN with reg2=0 and decode wreg=1 → ex_wreg_o=0.
4. MTHI reg1=0xDEADBEEF followed by MFHI on the next cycle → ex_wdata=0xDEADBEEF and hi_o=0xDEADBEEF. The MTHI cycle shows ex_wreg_o=0.
5. stall_i=1 held for 2 cycles during MTLO 0x55 → LO stays at its old value and mem_* hold. After release, LO=0x55 one edge later.
6. rst asserted mid-stream after MTHI 0x1 → after the edge hi_o=0, lo_o=0, mem_wreg_o=0 and mem_wdata_o=0, even with stall_i=1.
